// File: rtl/tmp_act_if.sv
// tmp_act_if: request/enable bundle between the temperature controller
// (master) and the heater/cooler actuator driver (slave).
interface tmp_act_if;
    logic heat_req;
    logic cool_req;
    logic heater_en;
    logic cooler_en;
    logic dead_active;
    logic conflict;
    logic fault;

    modport master (
        output heat_req, cool_req,
        input  heater_en, cooler_en, dead_active, conflict, fault
    );

    modport slave (
        input  heat_req, cool_req,
        output heater_en, cooler_en, dead_active, conflict, fault
    );
endinterface

// File: rtl/tmp_act_drv.sv
// tmp_act_drv: mutually exclusive heater/cooler drive with min on-time and dead-time.
// Optional max on-time limit with sticky fault when ACT_MAXON_EN is defined.
module tmp_act_drv #(
    parameter int MIN_ON = 16,
    parameter int DEAD   = 8,
    parameter int MAX_ON = 1024,
    parameter int CNT_W  = 16
) (
    input logic       clk,
    input logic       rst,
    tmp_act_if.slave  act
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAT = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;
    localparam logic [1:0] S_DEAD = 2'd3;

    if (MIN_ON < 1 || DEAD < 1 || MAX_ON <= MIN_ON) begin : g_bad_param
        $error("tmp_act_drv: illegal MIN_ON/DEAD/MAX_ON combination");
    end

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             conflict_q, fault_q;
    logic             on, exit_req, min_met, dead_done, normal_exit, maxon_hit;
    logic [1:0]       eval_st;

    assign on          = (state == S_HEAT) || (state == S_COOL);
    assign exit_req    = (state == S_HEAT) ? (~act.heat_req | act.cool_req)
                                           : (~act.cool_req | act.heat_req);
    assign min_met     = cnt >= CNT_W'(MIN_ON - 1);
    assign dead_done   = cnt == CNT_W'(DEAD - 1);
    assign normal_exit = on && exit_req && min_met;
    assign cnt_inc     = &cnt ? cnt : cnt + 1'b1;
    // A latched fault parks the driver in IDLE until reset
    assign eval_st     = fault_q                      ? S_IDLE :
                         act.heat_req & ~act.cool_req ? S_HEAT :
                         act.cool_req & ~act.heat_req ? S_COOL : S_IDLE;

`ifdef ACT_MAXON_EN
    assign maxon_hit = on && !normal_exit && (cnt == CNT_W'(MAX_ON - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else if (maxon_hit) fault_q <= 1'b1;
    end
`else
    assign maxon_hit = 1'b0;
    assign fault_q   = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt_inc;
        if (state == S_IDLE) begin
            state_n = eval_st;
            cnt_n   = '0;
        end else if (on) begin
            state_n = (normal_exit || maxon_hit) ? S_DEAD : state;
            cnt_n   = (normal_exit || maxon_hit) ? '0 : cnt_inc;
        end else if (dead_done) begin
            state_n = eval_st;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            conflict_q <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            conflict_q <= act.heat_req & act.cool_req;
        end
    end

    assign act.heater_en   = state == S_HEAT;
    assign act.cooler_en   = state == S_COOL;
    assign act.dead_active = state == S_DEAD;
    assign act.conflict    = conflict_q;
    assign act.fault       = fault_q;
endmodule

// File: tb/tb_tmp_act_drv.sv
// tb_tmp_act_drv: vector table, corner sequences and random traffic for tmp_act_drv.
module tb_tmp_act_drv;
    localparam int MIN_ON = 16;
    localparam int DEAD   = 8;
    localparam int MAX_ON = 1024;

    typedef struct {
        bit h, c;
        int n;
        bit eh, ec, ed, ecf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tmp_act_if bus();
    tmp_act_drv #(.MIN_ON(MIN_ON), .DEAD(DEAD), .MAX_ON(MAX_ON), .CNT_W(16))
        dut (.clk(clk), .rst(rst), .act(bus));

    int n_cmp = 0;
    int n_bad = 0;
    // Reference: absolute edge times of the last switch-on and switch-off
    int now = 0;
    int m_on = 0;
    int t_on = 0;
    int t_off = -100000;
    bit m_fault = 0;
    bit m_conf = 0;

    task automatic chk(input string nm, input logic a, input logic e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0;
        t_off = -100000;
        m_fault = 0;
        m_conf = 0;
    endtask

    task automatic model_edge(input bit h, input bit c);
        bit ex;
        now++;
        m_conf = h & c;
        ex = (m_on == 1) ? (!h || c) : (!c || h);
        if (m_on != 0) begin
            if (now - t_on >= MIN_ON && ex) begin
                m_on = 0;
                t_off = now;
            end
`ifdef ACT_MAXON_EN
            else if (now - t_on == MAX_ON) begin
                m_on = 0;
                t_off = now;
                m_fault = 1;
            end
`endif
        end else if (now - t_off >= DEAD) begin
            m_on = m_fault ? 0 : (h && !c) ? 1 : (c && !h) ? 2 : 0;
            if (m_on != 0) t_on = now;
        end
    endtask

    task automatic check_model();
        chk("heater_en", bus.heater_en, m_on == 1);
        chk("cooler_en", bus.cooler_en, m_on == 2);
        chk("dead_active", bus.dead_active, m_on == 0 && now - t_off < DEAD);
        chk("conflict", bus.conflict, m_conf);
        chk("fault", bus.fault, m_fault);
        chk("mutex", bus.heater_en & bus.cooler_en, 1'b0);
    endtask

    task automatic step(input bit h, input bit c);
        bus.heat_req = h;
        bus.cool_req = c;
        @(posedge clk);
        model_edge(h, c);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_heater", bus.heater_en, 1'b0);
        chk("rst_cooler", bus.cooler_en, 1'b0);
        chk("rst_dead", bus.dead_active, 1'b0);
        chk("rst_fault", bus.fault, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        int hi_cnt, hold;
        bit rh, rc;
        bus.heat_req = 1'b0;
        bus.cool_req = 1'b0;
        model_reset();
        @(negedge clk);
        check_model();
        rst = 1'b0;

        tbl.push_back('{1, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{1, 0, 2, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 12, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 7, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 3, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 40, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 1, 7, 0, 0, 1, 0});
        tbl.push_back('{0, 1, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 20, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 8, 0, 0, 0, 0});
        foreach (tbl[i]) begin
            repeat (tbl[i].n) step(tbl[i].h, tbl[i].c);
            chk($sformatf("tbl%0d_heater", i), bus.heater_en, tbl[i].eh);
            chk($sformatf("tbl%0d_cooler", i), bus.cooler_en, tbl[i].ec);
            chk($sformatf("tbl%0d_dead", i), bus.dead_active, tbl[i].ed);
            chk($sformatf("tbl%0d_conflict", i), bus.conflict, tbl[i].ecf);
        end

        // Asynchronous reset between edges mid-HEAT, then a fresh min-on
        repeat (5) step(1, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_heater", bus.heater_en, 1'b0);
        model_reset();
        bus.heat_req = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        model_edge(0, 0);
        @(negedge clk);
        check_model();
        step(1, 0);
        hi_cnt = 1;
        for (int k = 0; k < 30; k++) begin
            step(0, 0);
            if (bus.heater_en) hi_cnt++;
        end
        n_cmp++;
        if (hi_cnt != MIN_ON) begin
            n_bad++;
            $display("FAIL pulse_on_len: got %0d expected %0d", hi_cnt, MIN_ON);
        end

        // Long heat request: max on-time limit or unlimited
        hi_cnt = 0;
        for (int k = 0; k < 2000; k++) begin
            step(1, 0);
            if (bus.heater_en) hi_cnt++;
        end
`ifdef ACT_MAXON_EN
        chk("maxon_fault", bus.fault, 1'b1);
        chk("maxon_heater_off", bus.heater_en, 1'b0);
        n_cmp++;
        if (hi_cnt != MAX_ON) begin
            n_bad++;
            $display("FAIL maxon_len: got %0d expected %0d", hi_cnt, MAX_ON);
        end
`else
        chk("nolimit_heater", bus.heater_en, 1'b1);
        chk("nolimit_fault", bus.fault, 1'b0);
`endif
        do_reset();
        repeat (3) step(0, 0);

        // Random level requests held for random spans
        hold = 0;
        rh = 0;
        rc = 0;
        for (int k = 0; k < 4000; k++) begin
            if (hold == 0) begin
                {rh, rc} = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 40);
            end
            hold--;
            step(rh, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
